// File: rtl/project_pkg.sv
// Shared display types: character codes and segment constants.
package project_pkg;

   // Character code as produced by the display controller.
   typedef logic [4:0] code_t;

   localparam code_t CHAR_0    = 5'h00;
   localparam code_t CHAR_1    = 5'h01;
   localparam code_t CHAR_2    = 5'h02;
   localparam code_t CHAR_3    = 5'h03;
   localparam code_t CHAR_4    = 5'h04;
   localparam code_t CHAR_5    = 5'h05;
   localparam code_t CHAR_6    = 5'h06;
   localparam code_t CHAR_7    = 5'h07;
   localparam code_t CHAR_8    = 5'h08;
   localparam code_t CHAR_9    = 5'h09;
   localparam code_t CHAR_A    = 5'h0A;
   localparam code_t CHAR_B    = 5'h0B;
   localparam code_t CHAR_C    = 5'h0C;
   localparam code_t CHAR_D    = 5'h0D;
   localparam code_t CHAR_E    = 5'h0E;
   localparam code_t CHAR_F    = 5'h0F;
   localparam code_t CHAR_H    = 5'h10;
   localparam code_t CHAR_L    = 5'h11;
   localparam code_t CHAR_P    = 5'h12;
   localparam code_t CHAR_U    = 5'h13;
   localparam code_t CHAR_DASH = 5'h14;
   localparam code_t CHAR_BLK  = 5'h1F;

   // Segment pattern with every segment (and dp) dark.
   localparam logic [7:0] SEG_OFF = 8'h00;

endpackage

// File: rtl/seg_char_decode.sv
// Character code to 7-segment pattern {dp,g,f,e,d,c,b,a}; dp is never lit.
module seg_char_decode
   import project_pkg::*;
(
   input  code_t      code,
   output logic [7:0] pattern
);

   // Lookup table; blank and unmapped codes fall through to all-off.
   always_comb begin
      pattern = SEG_OFF;
      case (code)
         CHAR_0:    pattern = 8'h3F;
         CHAR_1:    pattern = 8'h06;
         CHAR_2:    pattern = 8'h5B;
         CHAR_3:    pattern = 8'h4F;
         CHAR_4:    pattern = 8'h66;
         CHAR_5:    pattern = 8'h6D;
         CHAR_6:    pattern = 8'h7D;
         CHAR_7:    pattern = 8'h07;
         CHAR_8:    pattern = 8'h7F;
         CHAR_9:    pattern = 8'h6F;
         CHAR_A:    pattern = 8'h77;
         CHAR_B:    pattern = 8'h7C;
         CHAR_C:    pattern = 8'h39;
         CHAR_D:    pattern = 8'h5E;
         CHAR_E:    pattern = 8'h79;
         CHAR_F:    pattern = 8'h71;
         CHAR_H:    pattern = 8'h76;
         CHAR_L:    pattern = 8'h38;
         CHAR_P:    pattern = 8'h73;
         CHAR_U:    pattern = 8'h3E;
         CHAR_DASH: pattern = 8'h40;
         default:   pattern = SEG_OFF;
      endcase
   end

endmodule

// File: rtl/seg_scan_driver.sv
// Time-multiplexed 8-digit 7-segment scanner with per-frame input snapshot,
// anti-ghosting dead time at the start of each slot, and blink gating.
module seg_scan_driver
   import project_pkg::*;
#(
   parameter int unsigned SCAN_DIV  = 100_000,
   parameter int unsigned DEAD      = 1_000,
   parameter int unsigned BLINK_DIV = 25_000_000
)
(
   input  logic            clk,
   input  logic            rst_n,
   input  code_t     [7:0] seg_data_in,
   input  logic      [7:0] seg_blink_in,
   output logic      [7:0] an_out,
   output logic      [7:0] seg_l,
   output logic      [7:0] seg_r
);

   localparam int unsigned SW = $clog2(SCAN_DIV);
   localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   localparam logic [SW-1:0] SCAN_LAST  = SW'(SCAN_DIV - 1);
   localparam logic [SW-1:0] DEAD_END   = SW'(DEAD);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);

   generate
      if (SCAN_DIV < 2) begin : g_bad_scan_div
         $fatal(1, "seg_scan_driver: SCAN_DIV must be >= 2");
      end
      if (DEAD >= SCAN_DIV) begin : g_bad_dead
         $fatal(1, "seg_scan_driver: DEAD must be < SCAN_DIV");
      end
      if (BLINK_DIV < 1) begin : g_bad_blink_div
         $fatal(1, "seg_scan_driver: BLINK_DIV must be >= 1");
      end
   endgenerate

   logic [SW-1:0] scan_cnt;
   logic [2:0]    idx;
   logic [BW-1:0] blink_cnt;
   logic          blink_phase;
   code_t [7:0]   shadow_data;
   logic  [7:0]   shadow_blink;

   logic          scan_wrap;
   logic          frame_wrap;
   logic          blink_wrap;
   logic [7:0]    char_pattern;
   logic [7:0]    slot_pattern;

   seg_char_decode u_decode (
      .code    (shadow_data[idx]),
      .pattern (char_pattern)
   );

   // Wrap strobes and the blink-gated pattern for the current slot.
   always_comb begin
      scan_wrap    = (scan_cnt == SCAN_LAST);
      frame_wrap   = scan_wrap && (idx == 3'd7);
      blink_wrap   = (blink_cnt == BLINK_LAST);
      slot_pattern = (shadow_blink[idx] && blink_phase) ? SEG_OFF : char_pattern;
   end

   // Slot counter and digit index; idx wraps 7->0 naturally at 3 bits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scan_cnt <= '0;
         idx      <= '0;
      end else if (scan_wrap) begin
         scan_cnt <= '0;
         idx      <= idx + 3'd1;
      end else begin
         scan_cnt <= scan_cnt + 1'b1;
      end
   end

   // Free-running blink half-period counter, independent of scanning.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (blink_wrap) begin
         blink_cnt   <= '0;
         blink_phase <= ~blink_phase;
      end else begin
         blink_cnt   <= blink_cnt + 1'b1;
      end
   end

   // Snapshot inputs once per frame so all 8 digits come from one sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow_data  <= {8{CHAR_BLK}};
         shadow_blink <= '0;
      end else if (frame_wrap) begin
         shadow_data  <= seg_data_in;
         shadow_blink <= seg_blink_in;
      end
   end

   // Registered pin drive: blank during dead time, else route to the half's bus.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         an_out <= '0;
         seg_l  <= '0;
         seg_r  <= '0;
      end else if (scan_cnt < DEAD_END) begin
         an_out <= '0;
         seg_l  <= '0;
         seg_r  <= '0;
      end else begin
         an_out <= 8'b1 << idx;
         seg_l  <= idx[2] ? slot_pattern : SEG_OFF;
         seg_r  <= idx[2] ? SEG_OFF : slot_pattern;
      end
   end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Scoreboard bench for seg_scan_driver with SCAN_DIV=4, DEAD=1, BLINK_DIV=64.
module tb_seg_scan_driver;
   import project_pkg::*;

   localparam int unsigned SD = 4;
   localparam int unsigned DT = 1;
   localparam int unsigned BD = 64;

   typedef struct packed {
      logic [7:0] an;
      logic [7:0] l;
      logic [7:0] r;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   code_t [7:0] seg_data_in;
   logic  [7:0] seg_blink_in;
   logic  [7:0] an_out;
   logic  [7:0] seg_l;
   logic  [7:0] seg_r;

   exp_t        exp_q[$];
   int unsigned n_vec = 0;
   int unsigned n_mis = 0;

   // Reference model state: cycles since reset release and frame snapshot.
   int unsigned m_cyc;
   code_t [7:0] m_data;
   logic  [7:0] m_blink;

   always #5 clk = ~clk;

   seg_scan_driver #(
      .SCAN_DIV  (SD),
      .DEAD      (DT),
      .BLINK_DIV (BD)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .seg_data_in  (seg_data_in),
      .seg_blink_in (seg_blink_in),
      .an_out       (an_out),
      .seg_l        (seg_l),
      .seg_r        (seg_r)
   );

   task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_mis++;
         $display("FAIL %s: got %02h expected %02h at t=%0t", tag, obs, exp, $time);
      end
   endtask

   function automatic logic [7:0] ref_pat(input code_t c);
      case (c)
         5'h00: return 8'h3F;  5'h01: return 8'h06;  5'h02: return 8'h5B;
         5'h03: return 8'h4F;  5'h04: return 8'h66;  5'h05: return 8'h6D;
         5'h06: return 8'h7D;  5'h07: return 8'h07;  5'h08: return 8'h7F;
         5'h09: return 8'h6F;  5'h0A: return 8'h77;  5'h0B: return 8'h7C;
         5'h0C: return 8'h39;  5'h0D: return 8'h5E;  5'h0E: return 8'h79;
         5'h0F: return 8'h71;  5'h10: return 8'h76;  5'h11: return 8'h38;
         5'h12: return 8'h73;  5'h13: return 8'h3E;  5'h14: return 8'h40;
         default: return 8'h00;
      endcase
   endfunction

   // Predict the output register contents produced by each rising edge.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_cyc   = 0;
         m_data  = {8{CHAR_BLK}};
         m_blink = 8'h00;
         exp_q.delete();
      end else begin
         int unsigned slot;
         int unsigned digit;
         logic [7:0]  pat;
         exp_t        e;
         slot  = m_cyc % SD;
         digit = (m_cyc / SD) % 8;
         pat   = ref_pat(m_data[digit]);
         if (m_blink[digit] && ((m_cyc / BD) % 2 == 1))
            pat = 8'h00;
         if (slot < DT) begin
            e = '0;
         end else begin
            e.an = 8'h01 << digit;
            e.l  = (digit >= 4) ? pat : 8'h00;
            e.r  = (digit < 4)  ? pat : 8'h00;
         end
         exp_q.push_back(e);
         m_cyc++;
         if (m_cyc % (8 * SD) == 0) begin
            m_data  = seg_data_in;
            m_blink = seg_blink_in;
         end
      end
   end

   // Compare DUT outputs against the scoreboard on the falling edge.
   always @(negedge clk) begin
      if (rst_n && exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         check_val("an_out", an_out, e.an);
         check_val("seg_l", seg_l, e.l);
         check_val("seg_r", seg_r, e.r);
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int unsigned guard;

      // Reset held for 5 cycles; outputs must stay dark.
      seg_data_in  = {CHAR_H, CHAR_E, CHAR_1, CHAR_1, CHAR_0, CHAR_BLK, CHAR_BLK, CHAR_BLK};
      seg_blink_in = 8'h00;
      rst_n        = 1'b0;
      repeat (5) begin
         @(negedge clk);
         check_val("rst_an", an_out, 8'h00);
         check_val("rst_seg_l", seg_l, 8'h00);
         check_val("rst_seg_r", seg_r, 8'h00);
      end
      rst_n = 1'b1;

      // Static text: blank first frame, text from the second frame.
      repeat (34) @(negedge clk);
      guard = 0;
      while (an_out != 8'h80 && guard < 40) begin @(negedge clk); guard++; end
      check_val("h_anode", an_out, 8'h80);
      check_val("h_seg_l", seg_l, 8'h76);
      check_val("h_seg_r", seg_r, 8'h00);
      guard = 0;
      while (an_out != 8'h08 && guard < 40) begin @(negedge clk); guard++; end
      check_val("zero_anode", an_out, 8'h08);
      check_val("zero_seg_r", seg_r, 8'h3F);

      // Mid-frame change at idx=3: rest of this frame keeps the old snapshot.
      guard = 0;
      while (((m_cyc / SD) % 8) != 3 && guard < 40) begin @(negedge clk); guard++; end
      seg_data_in = {CHAR_A, CHAR_B, CHAR_C, CHAR_D, CHAR_L, CHAR_P, CHAR_U, CHAR_DASH};
      repeat (72) @(negedge clk);

      // Blink on digit 0 across several half-periods.
      seg_data_in  = {CHAR_2, CHAR_3, CHAR_4, CHAR_5, CHAR_6, CHAR_7, CHAR_9, CHAR_8};
      seg_blink_in = 8'h01;
      repeat (300) @(negedge clk);

      // Blank and unmapped codes.
      seg_blink_in = 8'h00;
      seg_data_in  = {5'h1A, CHAR_BLK, 5'h15, CHAR_9, 5'h1E, CHAR_F, CHAR_BLK, 5'h17};
      repeat (72) @(negedge clk);

      // Async reset while digit 5 is lit.
      seg_data_in = {8{CHAR_8}};
      repeat (40) @(negedge clk);
      guard = 0;
      while (an_out != 8'h20 && guard < 40) begin @(negedge clk); guard++; end
      check_val("pre_arst_an", an_out, 8'h20);
      check_val("pre_arst_seg_l", seg_l, 8'h7F);
      #2 rst_n = 1'b0;
      #1;
      check_val("arst_an", an_out, 8'h00);
      check_val("arst_seg_l", seg_l, 8'h00);
      check_val("arst_seg_r", seg_r, 8'h00);
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      guard = 0;
      @(negedge clk);
      while (an_out == 8'h00 && guard < 40) begin @(negedge clk); guard++; end
      check_val("first_an_after_rst", an_out, 8'h01);
      repeat (70) @(negedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
      $finish;
   end

endmodule
